// File: rtl/ifu_prefetch_pkg.sv
// Shared widths and defaults for the instruction-fetch slice.
// Parameter defaults of ifu_prefetch and ifu_fifo come from here.
package ifu_prefetch_pkg;

    localparam int unsigned IFU_DATAWIDTH = 32;
    localparam int unsigned IFU_ADDRWIDTH = 8;
    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;

    // Occupancy counter must hold the value DEPTH itself.
    function automatic int unsigned ifu_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush empties it in one edge
// and overrides any push or pop in the same cycle.
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * IFU_DATAWIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = ifu_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_push    = push && !flush;
    assign do_pop     = pop && head_valid && !flush;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: issues reads to a 1-cycle synchronous RAM, buffers
// returned words with their PCs and hands them to decode; redirects flush all.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned          DATA_W   = IFU_DATAWIDTH,
    parameter int unsigned          ADDR_W   = IFU_ADDRWIDTH,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [DATA_W-1:0]    RESET_PC = DATA_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_pc_add_4
);

    localparam int unsigned CNT_W = ifu_cnt_w(DEPTH);

    logic [DATA_W-1:0]   fetch_pc;
    logic [DATA_W-1:0]   issue_pc;
    logic [DATA_W-1:0]   resp_pc;
    logic                resp_pend;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] fifo_head;

    // A pop in the same cycle is deliberately not credited, so the bound
    // holds even when decode stalls on the very next cycle.
    always_comb begin
        issue_pc = fetch_pc;
        imem_req = 1'b0;
        if (!rst_n) begin
            imem_req = 1'b0;
        end else if (redirect_valid) begin
            issue_pc = redirect_pc & ~DATA_W'(3);
            imem_req = 1'b1;
        end else begin
            imem_req = ({1'b0, count} + (CNT_W+1)'(resp_pend)) < (CNT_W+1)'(DEPTH);
        end
    end

    assign imem_addr = issue_pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            resp_pend <= 1'b0;
            resp_pc   <= '0;
        end else begin
            resp_pend <= imem_req;
            resp_pc   <= issue_pc;
            if (imem_req) fetch_pc <= issue_pc + DATA_W'(4);
        end
    end

    // Flush on redirect also drops the response of the older request.
    ifu_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (resp_pend),
        .pop        (id_ready),
        .flush      (redirect_valid),
        .push_data  ({resp_pc, imem_rdata}),
        .head       (fifo_head),
        .head_valid (id_valid),
        .count      (count)
    );

    assign id_pc       = fifo_head[2*DATA_W-1:DATA_W];
    assign id_instr    = fifo_head[DATA_W-1:0];
    assign id_pc_add_4 = id_pc + DATA_W'(4);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: cycle table after reset, hand-written corner
// sequences and a randomized run against an in-order PC stream model.
module tb_ifu_prefetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add_4;

    ifu_prefetch #(
        .DATA_W   (32),
        .ADDR_W   (8),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_add_4    (id_pc_add_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_of(imem_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: delivered PCs form a +4 stream from the last restart point,
    // and decode sees data from the second cycle after a restart onward.
    logic [31:0] exp_pc;
    int          since;

    logic        s_valid;
    logic        s_req;
    logic [7:0]  s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_add4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] t;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        s_valid = id_valid;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_pc    = id_pc;
        s_instr = id_instr;
        s_add4  = id_pc_add_4;
        check("model_valid", 32'(s_valid), 32'(since >= 2));
        if (rv) begin
            t = rpc;
            check("redir_req", 32'(s_req), 32'd1);
            check("redir_addr", 32'(s_addr), 32'(t[9:2]));
        end
        if (s_valid && rdy && !rv) begin
            check("model_pc", s_pc, exp_pc);
            check("model_instr", s_instr, word_of(exp_pc[9:2]));
            check("model_add4", s_add4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        if (rv) begin
            exp_pc = rpc & ~32'h3;
            since  = 1;
        end else begin
            since++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 8'd1};
        vecs[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 8'd2};
        vecs[3]  = '{1'b1, 1'b1, 32'h04, 1'b1, 8'd3};
        vecs[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 8'd4};
        vecs[5]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 8'd5};
        vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 8'd6};
        vecs[7]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 8'd7};
        vecs[8]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 8'd7};
        vecs[9]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 8'd7};
        vecs[10] = '{1'b1, 1'b1, 32'h10, 1'b1, 8'd7};
        vecs[11] = '{1'b1, 1'b1, 32'h14, 1'b1, 8'd8};

        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = '0;
        since          = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Cycle table from reset release
        @(negedge clk);
        rst_n  = 1'b1;
        since  = 0;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ready, 1'b0, 32'h0);
            check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
            check($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_valid)
                check($sformatf("tbl%0d_pc", i), s_pc, vecs[i].exp_pc);
        end

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(id_valid), 32'd0);
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        since  = 0;
        exp_pc = 32'h0;

        // Backpressure from reset: exactly four requests, then stall
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check($sformatf("bp%0d_req", i), 32'(s_req), 32'(i < 4));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        check("full_req", 32'(s_req), 32'd0);
        check("full_valid", 32'(s_valid), 32'd1);

        // Redirect into a full FIFO with a simultaneous handshake
        step(1'b1, 1'b1, 32'h40);
        check("rd40_head_valid", 32'(s_valid), 32'd1);
        step(1'b1, 1'b0, 32'h0);
        check("rd40_gap", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("rd40_valid", 32'(s_valid), 32'd1);
        check("rd40_pc", s_pc, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        check("rd40_next", s_pc, 32'h44);

        // Back-to-back redirects: only the last target is delivered
        step(1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b1, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        check("b2b_gap", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("b2b_pc", s_pc, 32'h100);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFFE);
        check("wrap_addr", 32'(s_addr), 32'hFF);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_addr_next", 32'(s_addr), 32'h00);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_pc", s_pc, 32'hFFFF_FFFC);
        check("wrap_add4", s_add4, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_pc_next", s_pc, 32'h0);

        // Randomized traffic against the stream model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit that decouples PC generation from decode through a small prefetch FIFO. It drives a synchronous instruction RAM (1-cycle read latency), captures returned words with their PCs, and presents them to the IDU over a valid/ready handshake. Redirects from branch and jump resolution flush all in-flight and buffered fetches. It sits between the PC redirect logic and the IDU, replacing the single-register fetch stage.

## Interface
Parameters:
- DATA_W, 32: PC and instruction width.
- ADDR_W, 8: instruction RAM word-address width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥ 4.
- RESET_PC, 0: PC fetched first after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- redirect_valid  in  1  flush the pipeline and restart fetch at redirect_pc.
- redirect_pc  in  DATA_W  new fetch PC; bits [1:0] are ignored.
- imem_req  out  1  read request to the instruction RAM this cycle.
- imem_addr  out  ADDR_W  word address, equal to PC[ADDR_W+1:2].
- imem_rdata  in  DATA_W  RAM data for the request issued the previous cycle.
- id_valid  out  1  FIFO head is valid.
- id_ready  in  1  IDU accepts the head.
- id_instr  out  DATA_W  head instruction.
- id_pc  out  DATA_W  head PC.
- id_pc_add_4  out  DATA_W  id_pc + 4, modulo 2^DATA_W.

## Operation
- State:
  - fetch_pc: next PC to request.
  - resp_pend: a response is due this cycle.
  - resp_pc: PC of the pending response.
  - FIFO of {pc, instr} with occupancy count.
- Issue rule, normal case: imem_req = (count + resp_pend < DEPTH). The same-cycle pop is not credited. imem_addr comes from fetch_pc, and fetch_pc advances by 4 on issue.
- Issue rule, redirect cycle: imem_req = 1 unconditionally. imem_addr comes from redirect_pc. fetch_pc becomes redirect_pc + 4 (low bits cleared).
- Response: when resp_pend = 1, {resp_pc, imem_rdata} is pushed to the FIFO at the end of the cycle. resp_pend and resp_pc are loaded from imem_req and the issued PC every cycle.
- Pop: a pop occurs when id_valid && id_ready. Push and pop in the same cycle leave count unchanged. Overflow is impossible by the issue rule.
- Redirect effects, in the same edge:
  - FIFO count cleared to 0.
  - The response arriving this cycle (from the older request) is discarded.
  - Any pop is ignored.
  - resp_pend is set for the redirect-target request.
- Redirect has priority over every other event, including a full FIFO and a simultaneous handshake.
- Consecutive redirects: only the last one's target reaches the FIFO.
- PC arithmetic wraps modulo 2^DATA_W. imem_addr wraps modulo 2^ADDR_W.
- id_instr, id_pc and id_pc_add_4 are don't-care while id_valid = 0.

## Timing
- Reset (asserted): fetch_pc = RESET_PC, resp_pend = 0, count = 0.
- Outputs during reset: id_valid = 0 and imem_req = 0. imem_addr = RESET_PC[ADDR_W+1:2].
- First request: imem_req rises in the first cycle after rst_n deasserts.
- Fetch latency: request at cycle T, data in the FIFO at the T+1 edge, id_valid at T+2. Redirect-to-id_valid latency is also 2 cycles.
- Throughput: 1 instruction/cycle sustained when id_ready is held high.
- Backpressure: with id_ready low, the FIFO fills to exactly DEPTH, then imem_req deasserts.
- Reset mid-operation: all in-flight and buffered instructions are lost immediately (asynchronous clear).

## Structure
- Shared defines header: `datawidth, `addrwidth, default RESET_PC. These are used as parameter defaults.
- Sub-module ifu_fifo: parametrised synchronous FIFO with width DATA_W*2 and depth DEPTH. It has push, pop, flush, count, head outputs and registered storage.
- Issue, response and redirect logic live in ifu_prefetch.

## Test plan
- Reset release, RESET_PC = 0, id_ready = 1:
  - imem_addr sequences 0, 1, 2, …
  - id_pc = 0x0, 0x4, 0x8 on consecutive cycles from cycle 2.
- id_ready = 0 for 10 cycles with DEPTH = 4:
  - exactly 4 entries (PCs 0x0–0xC) buffered; imem_req low after that.
  - resume id_ready: in-order delivery with no gaps or duplicates.
- Redirect to 0x40 while the FIFO is full with a simultaneous handshake:
  - the next id_valid appears 2 cycles later with id_pc = 0x40.
  - no stale PC is delivered.
- Back-to-back redirects to 0x80 then 0x100: first delivered id_pc = 0x100.
- Wrap: redirect to 0xFFFFFFFC gives id_pc = 0xFFFFFFFC, id_pc_add_4 = 0x0, then id_pc = 0x0.
- rst_n pulsed low mid-stream: id_valid drops asynchronously; fetch restarts at RESET_PC.
